fifo_drain_ctrl: RTL and testbench
==================================

FIFO_DRAIN_CTRL -- requirements
Module: fifo_drain_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of every FIFO word.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of pop_count.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  permits new FIFO reads when high.
REQ-006 SHALL have port fifo_empty  input  1  empty flag of the upstream synchronous FIFO.
REQ-007 SHALL have port fifo_rd_data  input  DATA_WIDTH  FIFO read data, valid the cycle after a read.
REQ-008 SHALL have port fifo_rd_en  output  1  FIFO read strobe.
REQ-009 SHALL have port out_valid  output  1  downstream word available.
REQ-010 SHALL have port out_data  output  DATA_WIDTH  downstream word.
REQ-011 SHALL have port out_ready  input  1  downstream accepts when high.
REQ-012 SHALL have port pop_count  output  CNT_WIDTH  count of completed downstream handshakes.
REQ-013 SHALL have port busy  output  1  high while buf_cnt or inflight is nonzero.

Function
REQ-014 SHALL use a 2-entry in-order output buffer with buf_cnt in {0,1,2}, states EMPTY/ONE/TWO, and a 1-bit inflight register.
REQ-015 SHALL define pop = out_valid & out_ready, meaning a handshake completes in that cycle.
REQ-016 SHALL drive fifo_rd_en = enable & ~fifo_empty & ((buf_cnt + inflight - pop) < 2), combinationally.
REQ-017 SHALL never assert fifo_rd_en while fifo_empty is high, so the FIFO read-error flag is never raised.
REQ-018 SHALL set inflight <= fifo_rd_en at each edge, since FIFO read latency is exactly 1 cycle.
REQ-019 SHALL capture fifo_rd_data into the buffer tail at the edge ending any cycle where inflight=1.
REQ-020 SHALL update buf_cnt next = buf_cnt + inflight - pop, and SHALL NOT let it exceed 2 or fall below 0.
REQ-021 SHALL drive out_valid = (buf_cnt != 0) and out_data = head entry; out_data is held stable while out_valid=1 and out_ready=0.
REQ-022 SHALL give 2-cycle latency: fifo_rd_en in cycle N, fifo_rd_data valid in N+1, out_valid high in N+2.
REQ-023 SHALL sustain 1 word/cycle when the FIFO is non-empty and out_ready is held high.
REQ-024 SHALL, on a simultaneous capture and pop with buf_cnt=1, leave buf_cnt at 1 with the new word at the head.
REQ-025 SHALL, on a simultaneous capture and pop with buf_cnt=2, shift the second entry to the head and write the new word to the tail.
REQ-026 SHALL, when enable is deasserted, stop new reads only; the in-flight word is still captured and buffered words still drain.
REQ-027 SHALL increment pop_count by 1 on each pop, wrapping modulo 2^CNT_WIDTH.
REQ-028 SHALL preserve FIFO order exactly, with no drop or duplication.

Reset
REQ-029 SHALL, while rst is high, force: out_valid=0, out_data=0, fifo_rd_en=0, busy=0, pop_count=0, buf_cnt=0, inflight=0, buffer entries=0.
REQ-030 SHALL, on rst assertion mid-operation, discard any in-flight read; the upstream FIFO SHALL be reset in the same cycle by the integrator.
REQ-031 SHALL allow no fifo_rd_en in the first cycle after rst deasserts unless fifo_empty=0 and enable=1.

Structure
REQ-032 SHALL place constants FIFO_RD_LATENCY=1 and DRAIN_BUF_DEPTH=2 in shared package edf_queue_pkg.
REQ-033 SHALL implement the 2-entry buffer as sub-module drain_out_buf with push, pop, din, dout, cnt ports; the read-issue logic stays in the top.

Verification
REQ-034 SHALL cover reset: assert rst with out_valid high -> out_valid=0, pop_count=0, fifo_rd_en=0 within the same cycle.
REQ-035 SHALL cover streaming: FIFO preloaded 0x0001..0x0008, out_ready=1 -> out_data 0x0001..0x0008 on 8 consecutive cycles, first 2 cycles after the first fifo_rd_en, pop_count=8.
REQ-036 SHALL cover backpressure: out_ready=0 with 5 words queued -> exactly 2 fifo_rd_en pulses, buf_cnt=2, out_data=word 1 held; release -> remaining 3 words delivered in order.
REQ-037 SHALL cover empty: single word then fifo_empty=1 -> one fifo_rd_en pulse, no further strobes, busy drops after delivery.
REQ-038 SHALL cover enable drop: enable falls in the same cycle as fifo_rd_en -> that word is still delivered and no further reads are issued.
REQ-039 SHALL cover wrap: CNT_WIDTH=4, 17 pops -> pop_count=1.

Source files
------------

// File: rtl/edf_queue_pkg.sv
// Shared constants and helpers for the FIFO drain controller and its output buffer.
package edf_queue_pkg;

    // Upstream FIFO returns data exactly one cycle after the read strobe.
    localparam int unsigned FIFO_RD_LATENCY = 1;
    // Number of words the output buffer can hold.
    localparam int unsigned DRAIN_BUF_DEPTH = 2;

    // Width of the buffer occupancy count (0..DRAIN_BUF_DEPTH).
    localparam int unsigned BUF_CNT_W = 2;
    // Width wide enough for buffered + in-flight words without overflow.
    localparam int unsigned OCC_W = $clog2(DRAIN_BUF_DEPTH + FIFO_RD_LATENCY) + 1;

    // Buffer occupancy states; the encoding equals the word count.
    localparam logic [1:0] BUF_EMPTY = 2'd0;
    localparam logic [1:0] BUF_ONE   = 2'd1;
    localparam logic [1:0] BUF_TWO   = 2'd2;

    // True when buffered + in-flight words, after this cycle's pop, leave room for one more read.
    function automatic logic has_room(
        input logic [BUF_CNT_W-1:0] cnt,
        input logic                 inflight,
        input logic                 pop
    );
        logic [OCC_W-1:0] occ;
        occ = OCC_W'(cnt) + OCC_W'(inflight) - OCC_W'(pop);
        return (occ < OCC_W'(DRAIN_BUF_DEPTH));
    endfunction

endpackage

// File: rtl/drain_out_buf.sv
// Two-entry in-order output buffer; head is presented downstream, tail absorbs
// the word arriving from the FIFO while the head is still waiting.
module drain_out_buf
    import edf_queue_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [BUF_CNT_W-1:0]  cnt
);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic [DATA_WIDTH-1:0] w_head_nxt;
    logic [DATA_WIDTH-1:0] w_tail_nxt;

    // State and storage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= BUF_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
        end
    end

    // Next occupancy and entry contents from push/pop; a pop with a push
    // advances the queue so the oldest remaining word is always at the head.
    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        case (r_state)
            BUF_EMPTY: begin
                if (push) begin
                    w_head_nxt  = din;
                    w_state_nxt = BUF_ONE;
                end
            end
            BUF_ONE: begin
                case ({push, pop})
                    2'b11: w_head_nxt = din;
                    2'b10: begin
                        w_tail_nxt  = din;
                        w_state_nxt = BUF_TWO;
                    end
                    2'b01: w_state_nxt = BUF_EMPTY;
                    default: ;
                endcase
            end
            BUF_TWO: begin
                // Read issue never lets a push arrive here without a pop.
                if (pop) begin
                    w_head_nxt = r_tail;
                    if (push) begin
                        w_tail_nxt = din;
                    end else begin
                        w_state_nxt = BUF_ONE;
                    end
                end
            end
            default: w_state_nxt = BUF_EMPTY;
        endcase
    end

    assign dout = r_head;
    assign cnt  = r_state;

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Drains a 1-cycle-latency synchronous FIFO into a valid/ready stream,
// issuing reads only when the output buffer is guaranteed room for the word.
module fifo_drain_ctrl
    import edf_queue_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [CNT_WIDTH-1:0]  pop_count,
    output logic                  busy
);

    logic                  r_inflight;
    logic [CNT_WIDTH-1:0]  r_pop_count;
    logic [BUF_CNT_W-1:0]  w_buf_cnt;
    logic [DATA_WIDTH-1:0] w_buf_dout;
    logic                  w_pop;
    logic                  w_rd_en;

    assign out_valid = (w_buf_cnt != BUF_EMPTY);
    assign out_data  = w_buf_dout;
    assign w_pop     = out_valid & out_ready;

    // Read only when enabled, the FIFO has data, and the word will fit; reset blocks reads outright.
    assign w_rd_en    = ~rst & enable & ~fifo_empty & has_room(w_buf_cnt, r_inflight, w_pop);
    assign fifo_rd_en = w_rd_en;

    assign busy      = out_valid | r_inflight;
    assign pop_count = r_pop_count;

    // Track the outstanding read and count completed handshakes (wrapping).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight  <= 1'b0;
            r_pop_count <= '0;
        end else begin
            r_inflight  <= w_rd_en;
            r_pop_count <= r_pop_count + CNT_WIDTH'(w_pop);
        end
    end

    drain_out_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk  (clk),
        .rst  (rst),
        .push (r_inflight),
        .pop  (w_pop),
        .din  (fifo_rd_data),
        .dout (w_buf_dout),
        .cnt  (w_buf_cnt)
    );

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Self-checking bench for fifo_drain_ctrl: FIFO model, cycle table, directed
// corner sequences, and randomized traffic checked against an order-preserving queue.
module tb_fifo_drain_ctrl;

    localparam int unsigned DW  = 16;
    localparam int unsigned CW  = 16;
    localparam int          MEM = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT signals
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_rd_en;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic [CW-1:0] pop_count;
    logic          busy;

    // Wrap-test DUT: never-empty FIFO, always-ready sink
    logic          rst2 = 1'b1;
    logic          en2 = 1'b1;
    logic          empty2 = 1'b0;
    logic [DW-1:0] rdata2 = 16'h5A5A;
    logic          rdy2 = 1'b1;
    logic          rd_en2;
    logic          vld2;
    logic [DW-1:0] dat2;
    logic [3:0]    pc2;
    logic          busy2;

    fifo_drain_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .pop_count(pop_count), .busy(busy)
    );

    fifo_drain_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) u_dut2 (
        .clk(clk), .rst(rst2), .enable(en2), .fifo_empty(empty2),
        .fifo_rd_data(rdata2), .fifo_rd_en(rd_en2), .out_valid(vld2),
        .out_data(dat2), .out_ready(rdy2), .pop_count(pc2), .busy(busy2)
    );

    // Upstream FIFO model: words written by the test become visible next cycle,
    // read data appears the cycle after the strobe, reset discards contents.
    logic [DW-1:0] wr_mem [MEM];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    always @(posedge clk) begin
        int rn;
        rn = rd_ptr;
        if (rst) begin
            rd_ptr       <= wr_ptr;
            fifo_empty   <= 1'b1;
            fifo_rd_data <= '0;
        end else begin
            if (fifo_rd_en && !fifo_empty) begin
                fifo_rd_data <= wr_mem[rd_ptr % MEM];
                rn = rd_ptr + 1;
            end
            rd_ptr     <= rn;
            fifo_empty <= (rn == wr_ptr);
        end
    end

    // Monitor: record strobes and handshakes with cycle stamps
    int            cyc = 0;
    int            rd_cyc[$];
    int            pop_cyc[$];
    logic [DW-1:0] pop_dat[$];
    int            rd_empty_errs = 0;
    int            hold_errs = 0;
    int            rd2 = 0;
    int            pops2 = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_dat = '0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (fifo_rd_en) rd_cyc.push_back(cyc);
            if (fifo_rd_en && fifo_empty) rd_empty_errs <= rd_empty_errs + 1;
            if (out_valid && out_ready) begin
                pop_cyc.push_back(cyc);
                pop_dat.push_back(out_data);
            end
            if (prev_stall && out_valid && (out_data != prev_dat)) hold_errs <= hold_errs + 1;
            prev_stall <= out_valid && !out_ready;
            prev_dat   <= out_data;
        end
        if (!rst2) begin
            if (rd_en2) rd2 <= rd2 + 1;
            if (vld2 && rdy2) pops2 <= pops2 + 1;
        end
    end

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] w);
        wr_mem[wr_ptr % MEM] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    // One row per cycle of the backpressure sequence
    typedef struct packed {
        logic          en;
        logic          rdy;
        logic          rd;
        logic          vld;
        logic [DW-1:0] dat;
        logic          bsy;
        logic [1:0]    cnt;
    } vec_t;

    vec_t tbl [11];

    initial begin
        logic [DW-1:0] sent[$];
        logic [DW-1:0] w;
        int b_rd, b_pop, first, k;
        logic seen;

        // 5 words queued behind a stalled sink, then released
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 2'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 2'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h00A1, 1'b1, 2'd1};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h00A1, 1'b1, 2'd2};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h00A1, 1'b1, 2'd2};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h00A1, 1'b1, 2'd2};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h00A2, 1'b1, 2'd1};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h00A3, 1'b1, 2'd1};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h00A4, 1'b1, 2'd1};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h00A5, 1'b1, 2'd1};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd0};

        // Reset state, with requests present that must be ignored
        repeat (2) tick();
        enable = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_rd_en", 32'(fifo_rd_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pop_count", 32'(pop_count), 0);
        chk("rst2_rd_en", 32'(rd_en2), 0);

        // Streaming: 8 words at full rate
        do_reset();
        b_rd = rd_cyc.size();
        b_pop = pop_dat.size();
        tick();
        enable = 1'b1;
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push(DW'(i));
        repeat (14) tick();
        chk("stream_rd_pulses", 32'(rd_cyc.size() - b_rd), 8);
        chk("stream_pops", 32'(pop_dat.size() - b_pop), 8);
        first = (rd_cyc.size() > b_rd) ? rd_cyc[b_rd] : 0;
        for (int i = 0; i < 8; i++) begin
            if (b_pop + i < pop_dat.size()) begin
                chk("stream_data", 32'(pop_dat[b_pop + i]), 32'(i + 1));
                chk("stream_cycle", 32'(pop_cyc[b_pop + i] - first), 32'(i + 2));
            end
        end
        chk("stream_pop_count", 32'(pop_count), 8);

        // Reset asserted while a word is being presented
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(DW'(16'h0B00 + i));
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        chk("rstmid_saw_valid", 32'(seen), 1);
        tick();
        rst = 1'b1;
        #1;
        chk("rstmid_valid", 32'(out_valid), 0);
        chk("rstmid_pop_count", 32'(pop_count), 0);
        chk("rstmid_rd_en", 32'(fifo_rd_en), 0);
        chk("rstmid_busy", 32'(busy), 0);

        // Backpressure cycle table
        do_reset();
        tick();
        enable = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(DW'(16'h00A1 + i));
        @(negedge clk);
        chk("bp_c0_rd_en", 32'(fifo_rd_en), 0);
        for (int i = 0; i < 11; i++) begin
            tick();
            enable = tbl[i].en;
            out_ready = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("bp_rd_en[%0d]", i), 32'(fifo_rd_en), 32'(tbl[i].rd));
            chk($sformatf("bp_valid[%0d]", i), 32'(out_valid), 32'(tbl[i].vld));
            chk($sformatf("bp_busy[%0d]", i), 32'(busy), 32'(tbl[i].bsy));
            chk($sformatf("bp_cnt[%0d]", i), 32'(u_dut.w_buf_cnt), 32'(tbl[i].cnt));
            if (tbl[i].vld) chk($sformatf("bp_data[%0d]", i), 32'(out_data), 32'(tbl[i].dat));
        end

        // Single word then the FIFO runs dry
        do_reset();
        b_rd = rd_cyc.size();
        b_pop = pop_dat.size();
        tick();
        enable = 1'b1;
        out_ready = 1'b1;
        push(16'h0055);
        repeat (8) tick();
        chk("empty_rd_pulses", 32'(rd_cyc.size() - b_rd), 1);
        chk("empty_pops", 32'(pop_dat.size() - b_pop), 1);
        if (pop_dat.size() > b_pop) chk("empty_data", 32'(pop_dat[b_pop]), 32'h55);
        chk("empty_busy", 32'(busy), 0);

        // Enable drops right after the cycle that issued a read
        do_reset();
        b_rd = rd_cyc.size();
        b_pop = pop_dat.size();
        tick();
        enable = 1'b1;
        out_ready = 1'b1;
        push(16'h0031);
        push(16'h0032);
        push(16'h0033);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = fifo_rd_en;
        end
        chk("endrop_saw_rd", 32'(seen), 1);
        tick();
        enable = 1'b0;
        repeat (6) tick();
        chk("endrop_rd_pulses", 32'(rd_cyc.size() - b_rd), 1);
        chk("endrop_pops", 32'(pop_dat.size() - b_pop), 1);
        if (pop_dat.size() > b_pop) chk("endrop_data", 32'(pop_dat[b_pop]), 32'h31);
        chk("endrop_busy", 32'(busy), 0);

        // Randomized traffic against an in-order reference queue
        do_reset();
        b_pop = pop_dat.size();
        for (int c = 0; c < 400; c++) begin
            tick();
            enable = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 1) == 1) begin
                w = DW'($urandom);
                push(w);
                sent.push_back(w);
            end
        end
        tick();
        enable = 1'b1;
        out_ready = 1'b1;
        k = 0;
        while (k < 2000 && !((pop_dat.size() - b_pop == sent.size()) && !busy)) begin
            tick();
            k++;
        end
        chk("rnd_count", 32'(pop_dat.size() - b_pop), 32'(sent.size()));
        for (int i = 0; i < sent.size(); i++) begin
            if (b_pop + i < pop_dat.size())
                chk($sformatf("rnd_data[%0d]", i), 32'(pop_dat[b_pop + i]), 32'(sent[i]));
        end
        chk("rnd_pop_count", 32'(pop_count), 32'(sent.size()));

        // Pop counter wrap on the 4-bit instance: 17 words
        tick();
        rst2 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (rd2 >= 17) begin
                en2 = 1'b0;
                seen = 1'b1;
            end
        end
        chk("wrap_reads_done", 32'(seen), 1);
        repeat (6) tick();
        chk("wrap_reads", 32'(rd2), 17);
        chk("wrap_pops", 32'(pops2), 17);
        chk("wrap_pop_count", 32'(pc2), 1);
        chk("wrap_busy", 32'(busy2), 0);
        chk("wrap_data", 32'(dat2), 32'h5A5A);

        // Global invariants over the whole run
        chk("rd_while_empty", 32'(rd_empty_errs), 0);
        chk("hold_stable", 32'(hold_errs), 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
